// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
// Shared encodings for the multicycle RV32I control unit and its datapath:
// FSM state type, opcode values, ALUOp and alucontrol codes, and the mux
// select encodings for resultsrc / alusrca / alusrcb / immsrc.
// Ports: none (package).
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JAL,
        S_BEQ
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format selected purely from the opcode.
    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder
// Maps ALUOp plus instruction function bits to the ALU operation code.
// Ports:
//   i_aluop      - ALUOp from the main FSM (add / sub / decode funct)
//   i_funct3     - instr[14:12]
//   i_op5        - instr[5], distinguishes R-type from I-type
//   i_funct7b5   - instr[30]
//   o_alucontrol - ALU operation code
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  aluop_t      i_aluop,
    input  logic [2:0]  i_funct3,
    input  logic        i_op5,
    input  logic        i_funct7b5,
    output logic [2:0]  o_alucontrol
);

    always_comb begin
        o_alucontrol = ALU_ADD;
        case (i_aluop)
            ALUOP_ADD: o_alucontrol = ALU_ADD;
            ALUOP_SUB: o_alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // funct7b5 only selects sub for R-type; addi ignores it
                    3'b000:  o_alucontrol = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alucontrol = ALU_SLT;
                    3'b110:  o_alucontrol = ALU_OR;
                    3'b111:  o_alucontrol = ALU_AND;
                    default: o_alucontrol = ALU_ADD;
                endcase
            end
            default: o_alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Moore main FSM, immediate decoder and ALU decoder for the multicycle
// RV32I datapath (lw, sw, R-type, I-type ALU, beq, jal).
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   op, funct3, funct7b5  - instruction fields held by the IR
//   zero                  - ALU result == 0
//   pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
//   regwrite, immsrc, alucontrol - datapath controls
//   illegal               - one-cycle pulse in DECODE on an unsupported opcode
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    output logic        pcwrite,
    output logic        adrsrc,
    output logic        memwrite,
    output logic        irwrite,
    output logic [1:0]  resultsrc,
    output logic [1:0]  alusrca,
    output logic [1:0]  alusrcb,
    output logic        regwrite,
    output logic [1:0]  immsrc,
    output logic [2:0]  alucontrol,
    output logic        illegal
);

    state_t      r_state;
    state_t      w_next;
    aluop_t      w_aluop;
    aluop_t      w_aluop_eff;
    logic        w_pcupdate;
    logic        w_branch;
    logic        w_adrsrc;
    logic        w_memwrite;
    logic        w_irwrite;
    logic        w_regwrite;
    logic        w_illegal;
    logic [1:0]  w_resultsrc;
    logic [1:0]  w_alusrca;
    logic [1:0]  w_alusrcb;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_pcupdate  = 1'b0;
        w_branch    = 1'b0;
        w_adrsrc    = 1'b0;
        w_memwrite  = 1'b0;
        w_irwrite   = 1'b0;
        w_regwrite  = 1'b0;
        w_illegal   = 1'b0;
        w_resultsrc = RES_ALUOUT;
        w_alusrca   = SRCA_PC;
        w_alusrcb   = SRCB_RS2;
        w_aluop     = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                w_irwrite   = 1'b1;
                w_alusrcb   = SRCB_FOUR;
                w_resultsrc = RES_ALURESULT;
                w_pcupdate  = 1'b1;
                w_next      = S_DECODE;
            end
            S_DECODE: begin
                w_alusrca = SRCA_OLDPC;
                w_alusrcb = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECR;
                    OP_ITYPE:     w_next = S_EXECI;
                    OP_JAL:       w_next = S_JAL;
                    OP_BEQ:       w_next = S_BEQ;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alusrca = SRCA_RS1;
                w_alusrcb = SRCB_IMM;
                w_next    = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adrsrc = 1'b1;
                w_next   = S_MEMWB;
            end
            S_MEMWB: begin
                w_resultsrc = RES_DATA;
                w_regwrite  = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_EXECR: begin
                w_alusrca = SRCA_RS1;
                w_alusrcb = SRCB_RS2;
                w_aluop   = ALUOP_FUNCT;
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                w_alusrca = SRCA_RS1;
                w_alusrcb = SRCB_IMM;
                w_aluop   = ALUOP_FUNCT;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_JAL: begin
                w_alusrca  = SRCA_OLDPC;
                w_alusrcb  = SRCB_FOUR;
                w_pcupdate = 1'b1;
                w_next     = S_ALUWB;
            end
            S_BEQ: begin
                w_alusrca = SRCA_RS1;
                w_alusrcb = SRCB_RS2;
                w_aluop   = ALUOP_SUB;
                w_branch  = 1'b1;
                w_next    = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset masks the decoded controls combinationally so no strobe
    // escapes in the reset cycle, whatever state the FSM was in.
    assign w_aluop_eff = reset ? ALUOP_ADD : w_aluop;

    alu_decoder u_alu_decoder (
        .i_aluop      (w_aluop_eff),
        .i_funct3     (funct3),
        .i_op5        (op[5]),
        .i_funct7b5   (funct7b5),
        .o_alucontrol (alucontrol)
    );

    assign pcwrite   = ~reset & (w_pcupdate | (w_branch & zero));
    assign adrsrc    = ~reset & w_adrsrc;
    assign memwrite  = ~reset & w_memwrite;
    assign irwrite   = ~reset & w_irwrite;
    assign regwrite  = ~reset & w_regwrite;
    assign illegal   = ~reset & w_illegal;
    assign resultsrc = reset ? RES_ALUOUT : w_resultsrc;
    assign alusrca   = reset ? SRCA_PC    : w_alusrca;
    assign alusrcb   = reset ? SRCB_RS2   : w_alusrcb;
    assign immsrc    = reset ? IMM_I      : imm_sel(op);

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
// Directed plus random instruction sequences; every cycle's control
// outputs are compared against a per-instruction cycle table.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        pcwrite;
    logic        adrsrc;
    logic        memwrite;
    logic        irwrite;
    logic [1:0]  resultsrc;
    logic [1:0]  alusrca;
    logic [1:0]  alusrcb;
    logic        regwrite;
    logic [1:0]  immsrc;
    logic [2:0]  alucontrol;
    logic        illegal;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .pcwrite    (pcwrite),
        .adrsrc     (adrsrc),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .resultsrc  (resultsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .regwrite   (regwrite),
        .immsrc     (immsrc),
        .alucontrol (alucontrol),
        .illegal    (illegal)
    );

    typedef struct packed {
        logic       pcwrite;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic       regwrite;
        logic [1:0] immsrc;
        logic [2:0] alucontrol;
        logic       illegal;
    } ctl_t;

    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;
    int unsigned n_total = 0;

    function automatic bit is_legal(input logic [6:0] o);
        return o inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h6f, 7'h63};
    endfunction

    // Cycles from FETCH back to the next FETCH.
    function automatic int unsigned instr_len(input logic [6:0] o);
        case (o)
            7'h03:   return 5;
            7'h23, 7'h33, 7'h13, 7'h6f: return 4;
            7'h63:   return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [2:0] alu_funct(input logic [2:0] f3, input logic op5, input logic f7);
        case (f3)
            3'd0:    return (op5 && f7) ? 3'b110 : 3'b010;
            3'd2:    return 3'b111;
            3'd6:    return 3'b001;
            3'd7:    return 3'b000;
            default: return 3'b010;
        endcase
    endfunction

    function automatic ctl_t rst_exp();
        ctl_t c;
        c = '0;
        c.alucontrol = 3'b010;
        return c;
    endfunction

    // Expected controls for cycle k (0 = fetch) of an instruction.
    function automatic ctl_t model(input logic [6:0] o, input logic [2:0] f3,
                                   input logic f7, input int unsigned k, input logic z);
        ctl_t c;
        c = '0;
        c.alucontrol = 3'b010;
        c.immsrc = (o == 7'h23) ? 2'd1 : (o == 7'h63) ? 2'd2 : (o == 7'h6f) ? 2'd3 : 2'd0;
        if (k == 0) begin
            c.irwrite = 1; c.alusrcb = 2; c.resultsrc = 2; c.pcwrite = 1;
            return c;
        end
        if (k == 1) begin
            c.alusrca = 1; c.alusrcb = 1; c.illegal = !is_legal(o);
            return c;
        end
        case (o)
            7'h03, 7'h23: begin
                if (k == 2) begin c.alusrca = 2; c.alusrcb = 1; end
                else if (k == 3) begin c.adrsrc = 1; c.memwrite = (o == 7'h23); end
                else begin c.resultsrc = 1; c.regwrite = 1; end
            end
            7'h33, 7'h13: begin
                if (k == 2) begin
                    c.alusrca = 2;
                    c.alusrcb = (o == 7'h13) ? 2'd1 : 2'd0;
                    c.alucontrol = alu_funct(f3, o[5], f7);
                end else c.regwrite = 1;
            end
            7'h6f: begin
                if (k == 2) begin c.alusrca = 1; c.alusrcb = 2; c.pcwrite = 1; end
                else c.regwrite = 1;
            end
            7'h63: begin
                c.alusrca = 2; c.alucontrol = 3'b110; c.pcwrite = z;
            end
            default: ;
        endcase
        return c;
    endfunction

    task automatic check(input string tag, input int unsigned k, input ctl_t exp);
        ctl_t got;
        got = {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
               regwrite, immsrc, alucontrol, illegal};
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc%0d: observed %05h expected %05h", tag, k, got, exp);
        end
    endtask

    // zmode: 0/1 fixed zero flag, 2 random each cycle. abort_at>0 asserts
    // reset in that cycle and ends the instruction there.
    task automatic run(input logic [31:0] w, input string tag, input int zmode,
                       input int unsigned abort_at);
        int unsigned n;
        n = instr_len(w[6:0]);
        for (int unsigned k = 0; k < n; k++) begin
            @(negedge clk);
            op       = w[6:0];
            funct3   = w[14:12];
            funct7b5 = w[30];
            zero     = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            if (abort_at != 0 && k == abort_at) begin
                reset = 1'b1;
                #1 check({tag, "/rst"}, k, rst_exp());
                return;
            end
            reset = 1'b0;
            #1 check(tag, k, model(w[6:0], w[14:12], w[30], k, zero));
        end
    endtask

    initial begin
        logic [6:0]  legal_ops [6];
        logic [31:0] w;
        logic [6:0]  o;
        int unsigned ab;
        legal_ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h6f, 7'h63};

        reset = 1'b1; op = 7'h6f; funct3 = 3'b000; funct7b5 = 1'b1; zero = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1 check("reset", 0, rst_exp());
        end

        run(32'h00402283, "lw_abort", 2, 3);
        run(32'h00e00093, "addi", 2, 0);
        run(32'h40110233, "sub", 2, 0);
        run(32'h00402283, "lw", 2, 0);
        run(32'h00502223, "sw", 2, 0);
        run(32'h00208463, "beq_z1", 1, 0);
        run(32'h00208463, "beq_z0", 0, 0);
        run(32'h0000007f, "illegal", 2, 0);
        run(32'h008000ef, "jal", 2, 0);

        for (int i = 0; i < 120; i++) begin
            w = $urandom;
            if ($urandom_range(0, 6) == 6) begin
                do o = 7'($urandom); while (is_legal(o));
            end else begin
                o = legal_ops[$urandom_range(0, 5)];
            end
            w[6:0] = o;
            ab = 0;
            if ($urandom_range(0, 7) == 0) ab = $urandom_range(1, instr_len(o) - 1);
            run(w, "rand", 2, ab);
        end

        if (n_pass + n_fail != n_total) $fatal(1, "FAIL tally: counters inconsistent");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
